// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_t;

    localparam int FLUSH_CYCLES_DEF = 1;
    localparam int FLUSH_CNT_W      = 3;
    localparam int STALL_CNT_W      = 32;
    localparam int MISP_CNT_W       = 16;
    localparam int REG_IDX_W        = 5;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exmem_stall;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } strobes_t;

    // Data memory busy: freeze everything up to EX/MEM and drain a bubble into MEM/WB.
    function automatic strobes_t mem_wait_strobes();
        strobes_t s;
        s             = '0;
        s.pc_stall    = 1'b1;
        s.ifid_stall  = 1'b1;
        s.idex_stall  = 1'b1;
        s.exmem_stall = 1'b1;
        s.memwb_flush = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between ID sources and EX load
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic                 i_rs1_en,
    input  logic                 i_rs2_en,
    input  logic [REG_IDX_W-1:0] i_rd,
    input  logic                 i_rd_en,
    input  logic                 i_load,
    output logic                 o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_live;

    // x0 never carries a real dependency.
    assign w_rd_live = i_load & i_rd_en & (i_rd != '0);
    assign w_rs1_hit = i_rs1_en & (i_rs1 == i_rd);
    assign w_rs2_hit = i_rs2_en & (i_rs2 == i_rd);
    assign o_hazard  = w_rd_live & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - central stall/flush controller with saturating stall and mispredict counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                     FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter logic [STALL_CNT_W-1:0] STALL_MAX    = '1,
    parameter logic [MISP_CNT_W-1:0]  MISP_MAX     = '1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_IDX_W-1:0]   id_rs1,
    input  logic [REG_IDX_W-1:0]   id_rs2,
    input  logic                   id_rs1_en,
    input  logic                   id_rs2_en,
    input  logic [REG_IDX_W-1:0]   ex_rd,
    input  logic                   ex_rd_en,
    input  logic                   ex_load,
    input  logic                   ex_mispredict,
    input  logic [31:0]            ex_target,
    input  logic                   mem_req,
    input  logic                   mem_ack,
    output logic                   pc_stall,
    output logic                   ifid_stall,
    output logic                   idex_stall,
    output logic                   exmem_stall,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   memwb_flush,
    output logic                   pc_redirect,
    output logic [31:0]            pc_target,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [MISP_CNT_W-1:0]  mispredict_cnt
);

    ctrl_state_t            r_state;
    ctrl_state_t            w_state_nxt;
    logic [FLUSH_CNT_W-1:0] r_flush_left;
    logic [FLUSH_CNT_W-1:0] w_flush_left_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic [MISP_CNT_W-1:0]  r_misp_cnt;

    logic                   w_load_use;
    logic                   w_mem_wait;
    logic                   w_blocked;
    logic                   w_accept_misp;
    logic                   w_redirect;
    logic [31:0]            w_target;
    strobes_t               w_strb;

    hazard_detect u_hazard_detect (
        .i_rs1    (id_rs1),
        .i_rs2    (id_rs2),
        .i_rs1_en (id_rs1_en),
        .i_rs2_en (id_rs2_en),
        .i_rd     (ex_rd),
        .i_rd_en  (ex_rd_en),
        .i_load   (ex_load),
        .o_hazard (w_load_use)
    );

    assign w_mem_wait = mem_req & ~mem_ack;
    // Once waiting, only the acknowledge releases the freeze.
    assign w_blocked  = (r_state == ST_MWAIT) ? ~mem_ack : w_mem_wait;

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_left_nxt = r_flush_left;
        w_strb           = '0;
        w_redirect       = 1'b0;
        w_target         = '0;
        w_accept_misp    = 1'b0;

        unique case (r_state)
            ST_RUN, ST_MWAIT: begin
                if (w_blocked) begin
                    w_strb      = mem_wait_strobes();
                    w_state_nxt = ST_MWAIT;
                end else if (ex_mispredict) begin
                    w_redirect        = 1'b1;
                    w_target          = ex_target;
                    w_strb.ifid_flush = 1'b1;
                    w_strb.idex_flush = 1'b1;
                    w_flush_left_nxt  = FLUSH_CNT_W'(FLUSH_CYCLES);
                    w_state_nxt       = ST_FLUSH;
                    w_accept_misp     = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (w_load_use) begin
                        w_strb.pc_stall   = 1'b1;
                        w_strb.ifid_stall = 1'b1;
                        w_strb.idex_flush = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                // A memory wait pauses the flush sequence without consuming a flush cycle.
                if (w_mem_wait) begin
                    w_strb = mem_wait_strobes();
                end else begin
                    w_strb.ifid_flush = 1'b1;
                    if (r_flush_left <= FLUSH_CNT_W'(1)) begin
                        w_flush_left_nxt = '0;
                        w_state_nxt      = ST_RUN;
                    end else begin
                        w_flush_left_nxt = r_flush_left - FLUSH_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt      = ST_RUN;
                w_flush_left_nxt = '0;
            end
        endcase

        if (rst) begin
            w_strb     = '0;
            w_redirect = 1'b0;
            w_target   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_flush_left   <= '0;
            r_stall_cycles <= '0;
            r_misp_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
            if (w_strb.pc_stall && (r_stall_cycles != STALL_MAX)) begin
                r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
            end
            if (w_accept_misp && (r_misp_cnt != MISP_MAX)) begin
                r_misp_cnt <= r_misp_cnt + MISP_CNT_W'(1);
            end
        end
    end

    assign pc_stall       = w_strb.pc_stall;
    assign ifid_stall     = w_strb.ifid_stall;
    assign idex_stall     = w_strb.idex_stall;
    assign exmem_stall    = w_strb.exmem_stall;
    assign ifid_flush     = w_strb.ifid_flush;
    assign idex_flush     = w_strb.idex_flush;
    assign memwb_flush    = w_strb.memwb_flush;
    assign pc_redirect    = w_redirect;
    assign pc_target      = w_target;
    assign stall_cycles   = r_stall_cycles;
    assign mispredict_cnt = r_misp_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    // Strobe vector bit order: pc_stall ifid_stall idex_stall exmem_stall ifid_flush idex_flush memwb_flush pc_redirect
    localparam logic [7:0] S_NONE = 8'b0000_0000;
    localparam logic [7:0] S_LU   = 8'b1100_0100;
    localparam logic [7:0] S_MW   = 8'b1111_0010;
    localparam logic [7:0] S_MP   = 8'b0000_1101;
    localparam logic [7:0] S_FL   = 8'b0000_1000;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_en, id_rs2_en, ex_rd_en, ex_load, ex_mispredict;
    logic [31:0] ex_target;
    logic        mem_req, mem_ack;

    logic        a_pc_stall, a_ifid_stall, a_idex_stall, a_exmem_stall;
    logic        a_ifid_flush, a_idex_flush, a_memwb_flush, a_pc_redirect;
    logic [31:0] a_pc_target, a_stall_cycles;
    logic [15:0] a_misp_cnt;
    logic        b_pc_stall, b_ifid_stall, b_idex_stall, b_exmem_stall;
    logic        b_ifid_flush, b_idex_flush, b_memwb_flush, b_pc_redirect;
    logic [31:0] b_pc_target, b_stall_cycles;
    logic [15:0] b_misp_cnt;
    logic [7:0]  a_strb, b_strb;

    int n_pass  = 0;
    int n_total = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .ex_rd(ex_rd), .ex_rd_en(ex_rd_en),
        .ex_load(ex_load), .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .idex_stall(a_idex_stall),
        .exmem_stall(a_exmem_stall), .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
        .memwb_flush(a_memwb_flush), .pc_redirect(a_pc_redirect), .pc_target(a_pc_target),
        .stall_cycles(a_stall_cycles), .mispredict_cnt(a_misp_cnt)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .STALL_MAX(32'd10), .MISP_MAX(16'd2)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .ex_rd(ex_rd), .ex_rd_en(ex_rd_en),
        .ex_load(ex_load), .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .idex_stall(b_idex_stall),
        .exmem_stall(b_exmem_stall), .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
        .memwb_flush(b_memwb_flush), .pc_redirect(b_pc_redirect), .pc_target(b_pc_target),
        .stall_cycles(b_stall_cycles), .mispredict_cnt(b_misp_cnt)
    );

    assign a_strb = {a_pc_stall, a_ifid_stall, a_idex_stall, a_exmem_stall,
                     a_ifid_flush, a_idex_flush, a_memwb_flush, a_pc_redirect};
    assign b_strb = {b_pc_stall, b_ifid_stall, b_idex_stall, b_exmem_stall,
                     b_ifid_flush, b_idex_flush, b_memwb_flush, b_pc_redirect};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
        ex_rd = '0; ex_rd_en = 1'b0; ex_load = 1'b0; ex_mispredict = 1'b0;
        ex_target = 32'h0000_0100; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_lu(input logic lu);
        id_rs1 = 5'd5; id_rs1_en = lu; ex_rd = 5'd5; ex_rd_en = lu; ex_load = lu;
        id_rs2 = '0; id_rs2_en = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit     m_wait  [2];
    int     m_flush [2];
    longint m_stall [2];
    int     m_misp  [2];
    int     m_fc    [2] = '{2, 3};
    longint m_smax  [2] = '{64'hFFFF_FFFF, 64'd10};
    int     m_mmax  [2] = '{65535, 2};

    function automatic bit model_blocked(input int k);
        return m_wait[k] ? !mem_ack : (mem_req && !mem_ack);
    endfunction

    function automatic logic [39:0] model_out(input int k);
        bit lu;
        lu = ex_load && ex_rd_en && (ex_rd != 0) &&
             ((id_rs1_en && id_rs1 == ex_rd) || (id_rs2_en && id_rs2 == ex_rd));
        if (rst) return '0;
        if (m_flush[k] > 0) return (mem_req && !mem_ack) ? {S_MW, 32'h0} : {S_FL, 32'h0};
        if (model_blocked(k)) return {S_MW, 32'h0};
        if (ex_mispredict) return {S_MP, ex_target};
        if (lu) return {S_LU, 32'h0};
        return '0;
    endfunction

    task automatic model_step(input int k);
        logic [39:0] o;
        bit blk;
        o   = model_out(k);
        blk = model_blocked(k);
        if (rst) begin
            m_wait[k] = 0; m_flush[k] = 0; m_stall[k] = 0; m_misp[k] = 0;
        end else begin
            if (o[39] && m_stall[k] < m_smax[k]) m_stall[k]++;
            if (m_flush[k] > 0) begin
                if (!(mem_req && !mem_ack)) m_flush[k]--;
            end else begin
                m_wait[k] = blk;
                if (o[32]) begin
                    m_flush[k] = m_fc[k];
                    if (m_misp[k] < m_mmax[k]) m_misp[k]++;
                end
            end
        end
    endtask

    // ---------------- table vectors (each from a fresh reset) ----------------
    typedef struct packed {
        logic [4:0] rs1, rs2;
        logic       e1, e2;
        logic [4:0] rd;
        logic       rde, ld, mp, rq, ak;
        logic [7:0] ex;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic [4:0] rs1, rs2, input logic e1, e2,
                                 input logic [4:0] rd, input logic rde, ld, mp, rq, ak,
                                 input logic [7:0] ex);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.e1 = e1; v.e2 = e2; v.rd = rd;
        v.rde = rde; v.ld = ld; v.mp = mp; v.rq = rq; v.ak = ak; v.ex = ex;
        return v;
    endfunction

    // ---------------- hand-written multi-cycle sequences ----------------
    typedef struct packed {
        logic       rst, lu, misp, mreq, mack;
        logic [7:0] ea, eb;
    } cyc_t;

    cyc_t seq[$];

    function automatic cyc_t mk(input logic r, lu, mp, rq, ak, input logic [7:0] ea, eb);
        cyc_t c;
        c.rst = r; c.lu = lu; c.misp = mp; c.mreq = rq; c.mack = ak; c.ea = ea; c.eb = eb;
        return c;
    endfunction

    task automatic run_seq(input string name);
        do_reset();
        foreach (seq[i]) begin
            set_lu(seq[i].lu);
            rst = seq[i].rst; ex_mispredict = seq[i].misp;
            mem_req = seq[i].mreq; mem_ack = seq[i].mack; ex_target = 32'h0000_0100;
            @(negedge clk);
            check($sformatf("%s_a_c%0d", name, i), a_strb, seq[i].ea);
            check($sformatf("%s_b_c%0d", name, i), b_strb, seq[i].eb);
            if (seq[i].ea[0]) check($sformatf("%s_a_target_c%0d", name, i), a_pc_target, 32'h100);
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        ex_mispredict = 1'b1; mem_req = 1'b1;
        @(negedge clk);
        check("rst_forces_a", {a_strb, a_pc_target}, 40'h0);
        check("rst_forces_b", {b_strb, b_pc_target}, 40'h0);
        tick();
        set_idle();
        @(negedge clk);
        check("reset_a_counters", {a_stall_cycles, a_misp_cnt}, 48'h0);
        check("reset_b_counters", {b_stall_cycles, b_misp_cnt}, 48'h0);
        check("reset_a_idle", a_strb, S_NONE);

        vecs.push_back(mkv(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, S_LU));
        vecs.push_back(mkv(0, 7, 0, 1, 7, 1, 1, 0, 0, 0, S_LU));
        vecs.push_back(mkv(5, 0, 0, 0, 5, 1, 1, 0, 0, 0, S_NONE));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, S_NONE));
        vecs.push_back(mkv(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, S_NONE));
        vecs.push_back(mkv(5, 0, 1, 0, 5, 0, 1, 0, 0, 0, S_NONE));
        vecs.push_back(mkv(5, 0, 1, 0, 5, 1, 1, 1, 0, 0, S_MP));
        vecs.push_back(mkv(5, 0, 1, 0, 5, 1, 1, 1, 1, 0, S_MW));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, S_NONE));
        vecs.push_back(mkv(3, 0, 1, 0, 3, 1, 1, 0, 1, 1, S_LU));
        vecs.push_back(mkv(9, 9, 1, 1, 4, 1, 1, 0, 0, 1, S_NONE));
        foreach (vecs[i]) begin
            do_reset();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_rs1_en = vecs[i].e1; id_rs2_en = vecs[i].e2;
            ex_rd = vecs[i].rd; ex_rd_en = vecs[i].rde; ex_load = vecs[i].ld;
            ex_mispredict = vecs[i].mp; mem_req = vecs[i].rq; mem_ack = vecs[i].ak;
            @(negedge clk);
            check($sformatf("vec%0d_a", i), a_strb, vecs[i].ex);
            check($sformatf("vec%0d_b", i), b_strb, vecs[i].ex);
            check($sformatf("vec%0d_target", i), a_pc_target, vecs[i].ex[0] ? 32'h100 : 32'h0);
        end

        seq = {};
        seq.push_back(mk(0, 1, 0, 0, 0, S_LU, S_LU));
        seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_NONE));
        run_seq("loaduse");
        check("loaduse_stall_cnt", a_stall_cycles, 32'd1);

        seq = {};
        seq.push_back(mk(0, 0, 1, 0, 0, S_MP, S_MP));
        seq.push_back(mk(0, 0, 0, 0, 0, S_FL, S_FL));
        seq.push_back(mk(0, 0, 0, 0, 0, S_FL, S_FL));
        seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_FL));
        seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_NONE));
        run_seq("misp");
        check("misp_cnt", a_misp_cnt, 16'd1);

        seq = {};
        seq.push_back(mk(0, 1, 1, 0, 0, S_MP, S_MP));
        seq.push_back(mk(0, 0, 0, 0, 0, S_FL, S_FL));
        seq.push_back(mk(0, 0, 0, 0, 0, S_FL, S_FL));
        seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_FL));
        run_seq("misp_lu");
        check("misp_lu_no_stall", a_stall_cycles, 32'd0);

        seq = {};
        for (int i = 0; i < 3; i++) seq.push_back(mk(0, 0, 1, 1, 0, S_MW, S_MW));
        seq.push_back(mk(0, 0, 1, 1, 1, S_MP, S_MP));
        seq.push_back(mk(0, 0, 0, 0, 0, S_FL, S_FL));
        run_seq("misp_mw");
        check("misp_mw_stall_cnt", a_stall_cycles, 32'd3);
        check("misp_mw_misp_cnt", a_misp_cnt, 16'd1);

        seq = {};
        seq.push_back(mk(0, 0, 1, 0, 0, S_MP, S_MP));
        seq.push_back(mk(0, 0, 0, 0, 0, S_FL, S_FL));
        seq.push_back(mk(0, 0, 0, 1, 0, S_MW, S_MW));
        seq.push_back(mk(0, 0, 0, 1, 0, S_MW, S_MW));
        seq.push_back(mk(0, 0, 0, 1, 1, S_FL, S_FL));
        seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_FL));
        seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_NONE));
        run_seq("flush_mw");

        seq = {};
        seq.push_back(mk(0, 0, 0, 1, 0, S_MW, S_MW));
        seq.push_back(mk(0, 0, 0, 1, 0, S_MW, S_MW));
        seq.push_back(mk(1, 0, 0, 1, 0, S_NONE, S_NONE));
        seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_NONE));
        run_seq("rst_mwait");
        check("rst_mwait_counters", {a_stall_cycles, b_stall_cycles}, 64'h0);

        seq = {};
        seq.push_back(mk(0, 0, 1, 0, 0, S_MP, S_MP));
        seq.push_back(mk(1, 0, 0, 0, 0, S_NONE, S_NONE));
        seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_NONE));
        run_seq("rst_flush");
        check("rst_flush_misp_cnt", a_misp_cnt, 16'd0);

        seq = {};
        for (int i = 0; i < 12; i++) seq.push_back(mk(0, 1, 0, 0, 0, S_LU, S_LU));
        for (int r = 0; r < 3; r++) begin
            seq.push_back(mk(0, 0, 1, 0, 0, S_MP, S_MP));
            seq.push_back(mk(0, 0, 0, 0, 0, S_FL, S_FL));
            seq.push_back(mk(0, 0, 0, 0, 0, S_FL, S_FL));
            seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_FL));
            seq.push_back(mk(0, 0, 0, 0, 0, S_NONE, S_NONE));
        end
        run_seq("sat");
        check("sat_a_stall", a_stall_cycles, 32'd12);
        check("sat_b_stall", b_stall_cycles, 32'd10);
        check("sat_a_misp", a_misp_cnt, 16'd3);
        check("sat_b_misp", b_misp_cnt, 16'd2);

        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_flush[k] = 0; m_stall[k] = 0; m_misp[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 63) == 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            id_rs1_en     = ($urandom_range(0, 3) != 0);
            id_rs2_en     = ($urandom_range(0, 1) != 0);
            ex_rd_en      = ($urandom_range(0, 3) != 0);
            ex_load       = ($urandom_range(0, 2) == 0);
            ex_mispredict = ($urandom_range(0, 7) == 0);
            ex_target     = $urandom;
            mem_req       = ($urandom_range(0, 3) == 0);
            mem_ack       = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            check($sformatf("rand_a_out_c%0d", c), {a_strb, a_pc_target}, model_out(0));
            check($sformatf("rand_b_out_c%0d", c), {b_strb, b_pc_target}, model_out(1));
            check($sformatf("rand_a_cnt_c%0d", c), {a_stall_cycles, a_misp_cnt},
                  {m_stall[0][31:0], 16'(m_misp[0])});
            check($sformatf("rand_b_cnt_c%0d", c), {b_stall_cycles, b_misp_cnt},
                  {m_stall[1][31:0], 16'(m_misp[1])});
            model_step(0);
            model_step(1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
